iter_div_unit: RTL and testbench
================================

Name: iter_div_unit

Overview:
- Multi-cycle radix-2 restoring integer divider. It is the responder side of the E-stage divide handshake.
- The ALU front end raises start and holds operands stable. It stalls while ready_o is low, then consumes the 64-bit {remainder, quotient} for the HI/LO write.
- Supports MIPS DIV (signed) and DIVU (unsigned), with annul for flush and exception kill.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- signed_div_i  in  1  1 = signed DIV, 0 = DIVU; sampled at start
- opdata1_i  in  WIDTH  dividend; sampled at start
- opdata2_i  in  WIDTH  divisor; sampled at start
- start_i  in  1  level request; held high by requester until accepted
- annul_i  in  1  abort the current operation; takes priority over all other inputs except rst
- accept_i  in  1  requester has consumed the result (E stage advancing)
- result_o  out  2*WIDTH  {remainder[63:32] -> HI, quotient[31:0] -> LO}
- ready_o  out  1  result valid
- busy_o  out  1  operation in flight (states PREP, CALC, FIX)

Behaviour:
- All state changes on posedge clk only. One clock domain, synchronous active-high reset.
- Reset values: state=IDLE, result_o=0, ready_o=0, busy_o=0, counter=0. Reset mid-operation discards all work in progress.
- States:
  - IDLE: if start_i && !annul_i, latch operands and sign mode, go to PREP.
  - PREP (1 cycle):
    - Signed mode: take absolute values of both operands. 0x80000000 stays 0x80000000 when treated as unsigned.
    - Record quotient sign as dividend sign XOR divisor sign; record remainder sign as dividend sign.
    - Divisor == 0: go straight to DONE with quotient = all ones and remainder = raw dividend, regardless of sign mode.
    - Otherwise clear the partial remainder, set counter=0, go to CALC.
  - CALC (WIDTH cycles):
    - Shift {partial remainder, dividend} left by 1.
    - Trial-subtract the divisor using a WIDTH+1-bit subtract. If the result is non-negative, keep the difference and set the quotient LSB to 1.
    - Increment the counter; after WIDTH iterations go to FIX.
  - FIX (1 cycle): negate quotient and/or remainder according to the recorded signs; load result_o; go to DONE.
  - DONE: ready_o=1 and result_o is held stable. On accept_i, go to IDLE and drop ready_o the next cycle. start_i is ignored in DONE.
- Latency: start sampled in cycle 0 means ready_o is high in cycle WIDTH+3 (cycle 35 for WIDTH=32).
  - Divide-by-zero: ready_o high in cycle 2.
- Back-to-back operation: a new start_i is seen in IDLE, one cycle after accept_i.
- annul_i in PREP, CALC, FIX or DONE: go to IDLE the next cycle; ready_o=0; result_o keeps its previous value. annul_i in IDLE blocks start_i.
- Simultaneous accept_i and annul_i in DONE: go to IDLE (same outcome either way).
- Overflow case 0x80000000 / 0xFFFFFFFF signed: quotient=0x80000000, remainder=0. This falls out naturally; there is no trap.
- Operand inputs are sampled only in IDLE; later changes are ignored.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- When defined, PREP also compares the absolute values. If |dividend| < |divisor| (divisor nonzero), go straight to FIX with quotient=0 and remainder=|dividend|. The normal sign fixup still applies, so ready_o is high in cycle 3.
- When not defined, all nonzero-divisor operations take the full WIDTH+3 cycles.
- Results are bit-identical with and without the macro.

Decomposition:
- Shared package div_pkg:
  - state enum div_state_t {IDLE, PREP, CALC, FIX, DONE}
  - constant DIV_ZERO_QUOT (all ones)
  - localparam DIV_LATENCY = WIDTH+3
- Sub-module div_step: combinational single restoring iteration. Inputs: partial remainder, dividend MSB, divisor. Outputs: next remainder, quotient bit. Instantiated once inside the CALC datapath.

Test Plan:
- DIVU 100 / 7, start held -> ready_o in cycle 35, result_o = 0x00000002_0000000E; accept_i -> ready_o=0 the next cycle.
- DIV 0xFFFFFFF9 (-7) / 2 -> result_o = 0xFFFFFFFF_FFFFFFFD (r=-1, q=-3). DIV 7 / -2 -> 0x00000001_FFFFFFFD.
- DIV 0x80000000 / 0xFFFFFFFF -> result_o = 0x00000000_80000000. DIVU of the same operands -> 0x80000000_00000000.
- Divide by zero, DIVU 5 / 0 -> ready_o in cycle 2, result_o = 0x00000005_FFFFFFFF.
- Start 100/7, pulse annul_i in cycle 10 -> IDLE in cycle 11, ready_o never rises. A new start 9/3 -> result_o = 0x00000000_00000003 in cycle +35.
- Assert rst in the middle of CALC -> all outputs 0 the next cycle. With DIV_EARLY_OUT_EN, DIVU 3 / 10 -> ready_o in cycle 3, result_o = 0x00000003_00000000.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the iterative divider
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } div_state_t;

  localparam int DIV_WIDTH = 32;

  // start-to-ready latency of a full-length divide
  localparam int DIV_LATENCY = DIV_WIDTH + 3;

  // quotient returned on divide-by-zero
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // shift in the next dividend bit and trial-subtract; the extra top bit is the borrow
  always_comb begin
    shifted = {rem_i, dvd_msb_i};
    diff    = shifted - {1'b0, dvs_i};
    q_bit_o = ~diff[WIDTH];
    rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/iter_div_unit.sv
// rtl/iter_div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU (option: DIV_EARLY_OUT_EN)
module iter_div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               accept_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_t         state_q, state_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;      // dividend, becomes the quotient during CALC
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               signed_q, signed_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               dvd_neg, dvs_neg;
  logic [WIDTH-1:0]   dvd_abs, dvs_abs;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;

  // magnitudes of the latched operands; the most negative value maps to itself
  always_comb begin
    dvd_neg = signed_q & dvd_q[WIDTH-1];
    dvs_neg = signed_q & dvs_q[WIDTH-1];
    dvd_abs = dvd_neg ? -dvd_q : dvd_q;
    dvs_abs = dvs_neg ? -dvs_q : dvs_q;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  // state register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  // next-state logic; annul wins over everything but reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i && !annul_i) state_d = PREP;
      PREP: begin
        if (annul_i)               state_d = IDLE;
        else if (dvs_q == '0)      state_d = DONE;
`ifdef DIV_EARLY_OUT_EN
        else if (dvd_abs < dvs_abs) state_d = FIX;
`endif
        else                       state_d = CALC;
      end
      CALC: begin
        if (annul_i)               state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX:  state_d = annul_i ? IDLE : DONE;
      DONE: if (annul_i || accept_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath updates; result only loads on a non-annulled completion
  always_comb begin
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          dvd_d    = opdata1_i;
          dvs_d    = opdata2_i;
          signed_d = signed_div_i;
        end
      end
      PREP: begin
        dvd_d  = dvd_abs;
        dvs_d  = dvs_abs;
        qneg_d = dvd_neg ^ dvs_neg;
        rneg_d = dvd_neg;
        rem_d  = '0;
        cnt_d  = '0;
        if (dvs_q == '0) begin
          // divide-by-zero reports the raw dividend, independent of sign mode
          if (!annul_i) result_d = {dvd_q, {WIDTH{1'b1}}};
        end
`ifdef DIV_EARLY_OUT_EN
        else if (dvd_abs < dvs_abs) begin
          dvd_d = '0;
          rem_d = dvd_abs;
        end
`endif
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
      end
      FIX: begin
        if (!annul_i) begin
          result_d = {(rneg_q ? -rem_q : rem_q), (qneg_q ? -dvd_q : dvd_q)};
        end
      end
      default: ;
    endcase
  end

  // status outputs decoded from the registered state
  always_comb begin
    ready_o = (state_q == DONE);
    busy_o  = (state_q == PREP) || (state_q == CALC) || (state_q == FIX);
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// tb/tb_iter_div_unit.sv - scoreboard bench for iter_div_unit
module tb_iter_div_unit;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        accept_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res;

  iter_div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .accept_i     (accept_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, DIV_ZERO_QUOT};
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int lat_of(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (sg && a[31]) ? -a : a;
    mb = (sg && b[31]) ? -b : b;
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 3;
`else
    if (ma < mb) return DIV_LATENCY;
`endif
    return DIV_LATENCY;
  endfunction

  // start is sampled at the next edge; operands are scrambled afterwards
  task automatic launch(input logic sg, input logic [31:0] a, input logic [31:0] b);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk); #1;
    start_i      = 1'b0;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~sg;
    check_eq("busy_after_start", {63'd0, busy_o}, 64'd1);
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 1;
    while (!ready_o && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_exp(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    int cyc;
    int lat;
    lat = lat_of(sg, a, b);
    exp_q.push_back(exp);
    launch(sg, a, b);
    wait_ready(cyc);
    check_eq("latency", 64'(cyc), 64'(lat));
    last_res = exp_q.pop_front();
    check_eq("result", result_o, last_res);
    accept_i = 1'b1;
    @(posedge clk); #1;
    accept_i = 1'b0;
    check_eq("ready_drop", {63'd0, ready_o}, 64'd0);
  endtask

  initial begin
    int cyc;
    int highs;
    logic sg;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_result", result_o, 64'd0);
    check_eq("reset_ready", {63'd0, ready_o}, 64'd0);
    check_eq("reset_busy", {63'd0, busy_o}, 64'd0);
    rst = 1'b0;

    run_exp(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    run_exp(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run_exp(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    run_exp(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run_exp(1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000);
    run_exp(1'b0, 32'd5, 32'd0, 64'h00000005_FFFFFFFF);
    run_exp(1'b1, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF);
    run_exp(1'b0, 32'd3, 32'd10, 64'h00000003_00000000);

    // annul during CALC: back to idle, no result, old result retained
    launch(1'b0, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
    end
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    check_eq("annul_busy", {63'd0, busy_o}, 64'd0);
    check_eq("annul_ready", {63'd0, ready_o}, 64'd0);
    check_eq("annul_result_held", result_o, last_res);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready_o) highs++;
    end
    check_eq("annul_no_ready", 64'(highs), 64'd0);
    run_exp(1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

    // annul in IDLE blocks start
    start_i = 1'b1;
    annul_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    check_eq("idle_annul_blocks", {63'd0, busy_o}, 64'd0);

    // simultaneous accept and annul in DONE
    launch(1'b1, 32'hFFFFFFF9, 32'd2);
    wait_ready(cyc);
    check_eq("done_annul_latency", 64'(cyc), 64'(DIV_LATENCY));
    check_eq("done_annul_result", result_o, 64'hFFFFFFFF_FFFFFFFD);
    annul_i  = 1'b1;
    accept_i = 1'b1;
    @(posedge clk); #1;
    annul_i  = 1'b0;
    accept_i = 1'b0;
    check_eq("done_annul_ready", {63'd0, ready_o}, 64'd0);
    check_eq("done_annul_held", result_o, 64'hFFFFFFFF_FFFFFFFD);

    // reset in the middle of CALC
    launch(1'b0, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrst_result", result_o, 64'd0);
    check_eq("midrst_ready", {63'd0, ready_o}, 64'd0);
    check_eq("midrst_busy", {63'd0, busy_o}, 64'd0);
    run_exp(1'b1, 32'd1000, 32'hFFFFFFFD, model(1'b1, 32'd1000, 32'hFFFFFFFD));

    // random vectors against the arithmetic model
    for (int i = 0; i < 12; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(1, 20));
        1:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
        2:       b = 32'd0;
        default: b = $urandom;
      endcase
      run_exp(sg, a, b, model(sg, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
